draw_tile_background: RTL and testbench

- Background tile stage placed directly upstream of the 16x16 tile ROM (8-bit address {row[3:0], col[3:0]}, 12-bit rgb, one-clock registered read).
- Takes the VGA timing/pixel stream, generates the tile ROM address with a frame-latched vertical scroll, and consumes the returned colour.
- Merges the tile colour over the incoming pixel inside a horizontal window and re-times every VGA signal to match the ROM latency.
- Output feeds the next draw stage (player/platform overlay).

---
 rtl/draw_tile_background_pkg.sv | 32 +++
 rtl/draw_tile_background_if.sv | 24 ++
 rtl/draw_tile_background_signal_delay.sv | 28 ++
 rtl/draw_tile_background.sv | 103 ++++++++++
 tb/tb_draw_tile_background.sv | 397 +++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/draw_tile_background_pkg.sv
// Shared constants, pixel bundle type and window helper
// for the background tile draw stage.
package draw_tile_background_pkg;

  localparam int COUNT_W          = 11;
  localparam int RGB_W            = 12;
  localparam int H_ACTIVE         = 800;
  localparam int V_ACTIVE         = 600;
  localparam int TILE_ROM_LATENCY = 1;
  localparam int TILE_SIZE_LOG2   = 4;

  typedef struct packed {
    logic [COUNT_W-1:0] hcount;
    logic [COUNT_W-1:0] vcount;
    logic               hsync;
    logic               vsync;
    logic               hblnk;
    logic               vblnk;
    logic [RGB_W-1:0]   rgb;
  } vga_t;

  function automatic logic in_window(
    input logic [COUNT_W-1:0] h,
    input int                 x0,
    input int                 x1
  );
    int hi;
    hi = int'(h);
    return (hi >= x0) && (hi <= x1);
  endfunction

endpackage

// File: rtl/draw_tile_background_if.sv
// VGA timing + pixel bundle between draw stages.
// master drives the stream, slave consumes it.
interface draw_tile_background_if;
  import draw_tile_background_pkg::*;

  logic [COUNT_W-1:0] hcount;
  logic [COUNT_W-1:0] vcount;
  logic               hsync;
  logic               vsync;
  logic               hblnk;
  logic               vblnk;
  logic [RGB_W-1:0]   rgb;

  modport master (
    output hcount, vcount, hsync, vsync,
    output hblnk, vblnk, rgb
  );

  modport slave (
    input hcount, vcount, hsync, vsync,
    input hblnk, vblnk, rgb
  );

endinterface

// File: rtl/draw_tile_background_signal_delay.sv
// Fixed-length register delay line, async active-low reset to 0.
// Ports: clk, rst_n, din[WIDTH], dout[WIDTH] (din delayed CLK_DEL clocks).
module signal_delay #(
  parameter int WIDTH   = 8,
  parameter int CLK_DEL = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [WIDTH-1:0] pipe_q [CLK_DEL];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pipe_q <= '{default: '0};
    end else begin
      pipe_q[0] <= din;
      for (int i = 1; i < CLK_DEL; i++) begin
        pipe_q[i] <= pipe_q[i-1];
      end
    end
  end

  assign dout = pipe_q[CLK_DEL-1];

endmodule

// File: rtl/draw_tile_background.sv
// Background tile stage: tile ROM addressing with frame-latched
// vertical scroll, colour merge in an hcount window, 3-clock retime.
// Ports: clk, rst_n, vga_i (slave), vga_o (master), scroll_y,
// tile_addr -> ROM, tile_rgb <- ROM (one clock later).
module draw_tile_background
  import draw_tile_background_pkg::*;
#(
  parameter int               REGION_X0   = 0,
  parameter int               REGION_X1   = H_ACTIVE - 1,
  parameter logic [RGB_W-1:0] TRANSPARENT = 12'hF0F,
  parameter int               SCROLL_W    = 10
) (
  input  logic                  clk,
  input  logic                  rst_n,
  draw_tile_background_if.slave  vga_i,
  draw_tile_background_if.master vga_o,
  input  logic [SCROLL_W-1:0]   scroll_y,
  output logic [7:0]            tile_addr,
  input  logic [RGB_W-1:0]      tile_rgb
);

  localparam int T = TILE_SIZE_LOG2;

  logic                vblnk_q;
  logic [SCROLL_W-1:0] scroll_q, scroll_d;
  logic [7:0]          addr_q, addr_d;
  logic [T-1:0]        row_d;
  vga_t                in_s, d2_s;
  vga_t                out_q, out_d;

  always_comb begin
    in_s        = '0;
    in_s.hcount = vga_i.hcount;
    in_s.vcount = vga_i.vcount;
    in_s.hsync  = vga_i.hsync;
    in_s.vsync  = vga_i.vsync;
    in_s.hblnk  = vga_i.hblnk;
    in_s.vblnk  = vga_i.vblnk;
    in_s.rgb    = vga_i.rgb;
  end

  // Latch only on the blanking rising edge so a
  // frame never sees two different scroll values.
  assign scroll_d = (vga_i.vblnk && !vblnk_q)
                  ? scroll_y : scroll_q;

  // Row wraps every tile, so the sum is kept mod 16.
  assign row_d  = T'(vga_i.vcount + COUNT_W'(scroll_q));
  assign addr_d = {row_d, vga_i.hcount[T-1:0]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vblnk_q  <= 1'b0;
      scroll_q <= '0;
      addr_q   <= '0;
    end else begin
      vblnk_q  <= vga_i.vblnk;
      scroll_q <= scroll_d;
      addr_q   <= addr_d;
    end
  end

  assign tile_addr = addr_q;

  // Two clocks here plus the output register match
  // the address register + ROM read latency.
  signal_delay #(
    .WIDTH   ($bits(vga_t)),
    .CLK_DEL (TILE_ROM_LATENCY + 1)
  ) u_delay (
    .clk   (clk),
    .rst_n (rst_n),
    .din   (in_s),
    .dout  (d2_s)
  );

  always_comb begin
    out_d = d2_s;
    if (d2_s.hblnk || d2_s.vblnk) begin
      out_d.rgb = '0;
    end else if (in_window(d2_s.hcount, REGION_X0, REGION_X1)
                 && (tile_rgb != TRANSPARENT)) begin
      out_d.rgb = tile_rgb;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q <= '0;
    end else begin
      out_q <= out_d;
    end
  end

  assign vga_o.hcount = out_q.hcount;
  assign vga_o.vcount = out_q.vcount;
  assign vga_o.hsync  = out_q.hsync;
  assign vga_o.vsync  = out_q.vsync;
  assign vga_o.hblnk  = out_q.hblnk;
  assign vga_o.vblnk  = out_q.vblnk;
  assign vga_o.rgb    = out_q.rgb;

endmodule

// File: tb/tb_draw_tile_background.sv
// Directed self-checking bench for draw_tile_background.
// Two instances: full-width window and a 100..199 window.
module tb_draw_tile_background;
  import draw_tile_background_pkg::*;

  typedef struct packed {
    logic [10:0] h;
    logic [10:0] v;
    logic        hs;
    logic        vs;
    logic        hb;
    logic        vb;
    logic [11:0] rgb;
    logic [3:0]  sc;
  } px_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [9:0]  scroll_y;
  logic [7:0]  addr_a, addr_b;
  logic [11:0] trgb_a, trgb_b;
  logic [11:0] rom [256];
  logic [3:0]  sc_cur;
  logic        prev_vb;
  px_t         last_px;
  int          n_tests = 0;
  int          n_fail  = 0;

  always #5 clk = ~clk;

  draw_tile_background_if in_if ();
  draw_tile_background_if out_a ();
  draw_tile_background_if out_b ();

  draw_tile_background u_dut_a (
    .clk       (clk),
    .rst_n     (rst_n),
    .vga_i     (in_if),
    .vga_o     (out_a),
    .scroll_y  (scroll_y),
    .tile_addr (addr_a),
    .tile_rgb  (trgb_a)
  );

  draw_tile_background #(
    .REGION_X0 (100),
    .REGION_X1 (199)
  ) u_dut_b (
    .clk       (clk),
    .rst_n     (rst_n),
    .vga_i     (in_if),
    .vga_o     (out_b),
    .scroll_y  (scroll_y),
    .tile_addr (addr_b),
    .tile_rgb  (trgb_b)
  );

  // Tile ROM model, one-clock registered read.
  always @(posedge clk) begin
    trgb_a <= rom[addr_a];
    trgb_b <= rom[addr_b];
  end

  logic [37:0] obs_a, obs_b;
  assign obs_a = {out_a.hcount, out_a.vcount, out_a.hsync,
                  out_a.vsync, out_a.hblnk, out_a.vblnk, out_a.rgb};
  assign obs_b = {out_b.hcount, out_b.vcount, out_b.hsync,
                  out_b.vsync, out_b.hblnk, out_b.vblnk, out_b.rgb};

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(
    input int          h,
    input int          v,
    input logic        hs,
    input logic        vs,
    input logic        hb,
    input logic        vb,
    input logic [11:0] rgb
  );
    in_if.hcount = 11'(h);
    in_if.vcount = 11'(v);
    in_if.hsync  = hs;
    in_if.vsync  = vs;
    in_if.hblnk  = hb;
    in_if.vblnk  = vb;
    in_if.rgb    = rgb;
    last_px.h    = 11'(h);
    last_px.v    = 11'(v);
    last_px.hs   = hs;
    last_px.vs   = vs;
    last_px.hb   = hb;
    last_px.vb   = vb;
    last_px.rgb  = rgb;
    last_px.sc   = sc_cur;
    if (vb && !prev_vb && rst_n) sc_cur = scroll_y[3:0];
    prev_vb = rst_n ? vb : 1'b0;
  endtask

  task automatic flush(input int n);
    repeat (n) begin
      drive(0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 12'h000);
      tick();
    end
  endtask

  function automatic logic [11:0] exp_rgb(input px_t p,
                                          input int x0,
                                          input int x1);
    logic [3:0]  r;
    logic [11:0] t;
    if (p.hb || p.vb) return 12'h000;
    r = p.v[3:0] + p.sc;
    t = rom[{r, p.h[3:0]}];
    if (int'(p.h) >= x0 && int'(p.h) <= x1 && t != 12'hF0F)
      return t;
    return p.rgb;
  endfunction

  task automatic test_reset;
    rst_n    = 1'b1;
    scroll_y = '0;
    sc_cur   = '0;
    prev_vb  = 1'b0;
    drive(5, 7, 1'b1, 1'b1, 1'b0, 1'b0, 12'hABC);
    #2 rst_n = 1'b0;
    #1;
    n_tests++;
    if ({obs_a, addr_a} !== '0) begin
      n_fail++;
      $display("FAIL reset_a: got %h want 0", {obs_a, addr_a});
    end
    n_tests++;
    if ({obs_b, addr_b} !== '0) begin
      n_fail++;
      $display("FAIL reset_b: got %h want 0", {obs_b, addr_b});
    end
    tick();
    tick();
    n_tests++;
    if ({obs_a, addr_a} !== '0) begin
      n_fail++;
      $display("FAIL reset_hold: got %h want 0", {obs_a, addr_a});
    end
    rst_n   = 1'b1;
    sc_cur  = '0;
    prev_vb = 1'b0;
    drive(37, 18, 1'b1, 1'b0, 1'b0, 1'b0, 12'h123);
    tick();
    n_tests++;
    if (addr_a !== 8'h25) begin
      n_fail++;
      $display("FAIL addr_noscroll: got %h want 25", addr_a);
    end
    drive(38, 18, 1'b1, 1'b0, 1'b0, 1'b0, 12'h124);
    tick();
    drive(39, 18, 1'b1, 1'b0, 1'b0, 1'b0, 12'h125);
    tick();
    n_tests++;
    if (obs_a !== {11'd37, 11'd18, 4'b1000, 12'h258}) begin
      n_fail++;
      $display("FAIL first_out_a: got %h want %h", obs_a,
               {11'd37, 11'd18, 4'b1000, 12'h258});
    end
    n_tests++;
    if (out_b.rgb !== 12'h123) begin
      n_fail++;
      $display("FAIL first_out_b: got %h want 123", out_b.rgb);
    end
  endtask

  task automatic test_scroll;
    scroll_y = 10'd5;
    drive(0, 600, 1'b0, 1'b0, 1'b0, 1'b1, 12'h000);
    tick();
    drive(37, 18, 1'b0, 1'b0, 1'b0, 1'b0, 12'h000);
    tick();
    n_tests++;
    if (addr_a !== 8'h75) begin
      n_fail++;
      $display("FAIL addr_scroll5: got %h want 75", addr_a);
    end
    scroll_y = 10'd3;
    drive(0, 600, 1'b0, 1'b0, 1'b0, 1'b1, 12'h000);
    tick();
    scroll_y = 10'd9;
    drive(37, 18, 1'b0, 1'b0, 1'b0, 1'b0, 12'h000);
    tick();
    n_tests++;
    if (addr_a !== 8'h55) begin
      n_fail++;
      $display("FAIL scroll_hold0: got %h want 55", addr_a);
    end
    drive(100, 19, 1'b0, 1'b0, 1'b0, 1'b0, 12'h000);
    tick();
    n_tests++;
    if (addr_a !== 8'h64) begin
      n_fail++;
      $display("FAIL scroll_hold1: got %h want 64", addr_a);
    end
    drive(0, 600, 1'b0, 1'b0, 1'b0, 1'b1, 12'h000);
    tick();
    scroll_y = 10'd2;
    drive(1, 600, 1'b0, 1'b0, 1'b0, 1'b1, 12'h000);
    tick();
    drive(0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 12'h000);
    tick();
    n_tests++;
    if (addr_a !== 8'h90) begin
      n_fail++;
      $display("FAIL scroll_new: got %h want 90", addr_a);
    end
    drive(5, 1, 1'b0, 1'b0, 1'b0, 1'b0, 12'h000);
    tick();
    n_tests++;
    if (addr_a !== 8'hA5) begin
      n_fail++;
      $display("FAIL scroll_new2: got %h want a5", addr_a);
    end
  endtask

  task automatic test_merge;
    scroll_y = '0;
    drive(0, 600, 1'b0, 1'b0, 1'b0, 1'b1, 12'h000);
    tick();
    rom[8'h25] = 12'h48C;
    drive(37, 18, 1'b0, 1'b0, 1'b0, 1'b0, 12'h123);
    tick();
    flush(2);
    n_tests++;
    if (out_a.rgb !== 12'h48C) begin
      n_fail++;
      $display("FAIL merge_tile: got %h want 48c", out_a.rgb);
    end
    rom[8'h25] = 12'hF0F;
    drive(37, 18, 1'b0, 1'b0, 1'b0, 1'b0, 12'h123);
    tick();
    flush(2);
    n_tests++;
    if (out_a.rgb !== 12'h123) begin
      n_fail++;
      $display("FAIL merge_transp: got %h want 123", out_a.rgb);
    end
    rom[8'h25] = 12'h258;
    drive(37, 18, 1'b0, 1'b0, 1'b1, 1'b0, 12'h123);
    tick();
    flush(2);
    n_tests++;
    if (out_a.rgb !== 12'h000) begin
      n_fail++;
      $display("FAIL merge_hblank: got %h want 000", out_a.rgb);
    end
    drive(37, 18, 1'b0, 1'b0, 1'b0, 1'b1, 12'h123);
    tick();
    flush(2);
    n_tests++;
    if (out_a.rgb !== 12'h000) begin
      n_fail++;
      $display("FAIL merge_vblank: got %h want 000", out_a.rgb);
    end
  endtask

  task automatic test_window;
    int          hv [4];
    logic [11:0] wa [4];
    logic [11:0] wb [4];
    hv = '{99, 100, 199, 200};
    wa = '{12'h038, 12'h048, 12'h078, 12'h088};
    wb = '{12'h777, 12'h048, 12'h078, 12'h777};
    for (int i = 0; i < 6; i++) begin
      if (i < 4)
        drive(hv[i], 0, 1'b0, 1'b0, 1'b0, 1'b0, 12'h777);
      else
        drive(0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 12'h000);
      tick();
      if (i >= 2) begin
        n_tests++;
        if (out_b.rgb !== wb[i-2]) begin
          n_fail++;
          $display("FAIL win_b h=%0d: got %h want %h",
                   hv[i-2], out_b.rgb, wb[i-2]);
        end
        n_tests++;
        if (out_a.rgb !== wa[i-2]) begin
          n_fail++;
          $display("FAIL win_a h=%0d: got %h want %h",
                   hv[i-2], out_a.rgb, wa[i-2]);
        end
      end
    end
  endtask

  task automatic test_frame;
    int    lines [9];
    px_t   q [$];
    px_t   p;
    logic  hb, hs, vb, vs;
    int    shown;
    logic [37:0] ea, eb;
    lines    = '{597, 598, 599, 600, 601, 602, 627, 0, 1};
    scroll_y = 10'd6;
    shown    = 0;
    for (int li = 0; li < 11; li++) begin
      for (int h = 0; h < 1056; h++) begin
        if (li < 9) begin
          hb = (h >= 800);
          hs = (h >= 840) && (h <= 967);
          vb = (lines[li] >= 600);
          vs = (lines[li] >= 601) && (lines[li] <= 604);
          drive(h, lines[li], hs, vs, hb, vb,
                12'(h * 7 + lines[li] * 3));
        end else begin
          if (h >= 2) break;
          drive(0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 12'h000);
        end
        q.push_back(last_px);
        tick();
        if (q.size() == 3) begin
          p  = q.pop_front();
          ea = {p.h, p.v, p.hs, p.vs, p.hb, p.vb,
                exp_rgb(p, 0, 799)};
          eb = {p.h, p.v, p.hs, p.vs, p.hb, p.vb,
                exp_rgb(p, 100, 199)};
          n_tests++;
          if (obs_a !== ea) begin
            n_fail++;
            if (shown < 10)
              $display("FAIL frame_a h=%0d v=%0d: got %h want %h",
                       p.h, p.v, obs_a, ea);
            shown++;
          end
          n_tests++;
          if (obs_b !== eb) begin
            n_fail++;
            if (shown < 10)
              $display("FAIL frame_b h=%0d v=%0d: got %h want %h",
                       p.h, p.v, obs_b, eb);
            shown++;
          end
        end
      end
    end
  endtask

  task automatic test_reset_midframe;
    for (int h = 10; h < 15; h++) begin
      drive(h, 20, 1'b0, 1'b0, 1'b0, 1'b0, 12'h3C3);
      tick();
    end
    rst_n = 1'b0;
    #1;
    n_tests++;
    if ({obs_a, addr_a} !== '0) begin
      n_fail++;
      $display("FAIL midreset_a: got %h want 0", {obs_a, addr_a});
    end
    n_tests++;
    if ({obs_b, addr_b} !== '0) begin
      n_fail++;
      $display("FAIL midreset_b: got %h want 0", {obs_b, addr_b});
    end
    tick();
    rst_n   = 1'b1;
    sc_cur  = '0;
    prev_vb = 1'b0;
    drive(300, 40, 1'b0, 1'b1, 1'b0, 1'b0, 12'h5A5);
    tick();
    n_tests++;
    if (addr_a !== 8'h8C) begin
      n_fail++;
      $display("FAIL midreset_addr: got %h want 8c", addr_a);
    end
    flush(2);
    n_tests++;
    if (obs_a !== {11'd300, 11'd40, 4'b0100, 12'h8C8}) begin
      n_fail++;
      $display("FAIL midreset_out: got %h want %h", obs_a,
               {11'd300, 11'd40, 4'b0100, 12'h8C8});
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) rom[i] = {i[7:0], 4'h8};
    test_reset();
    test_scroll();
    test_merge();
    test_window();
    test_frame();
    test_reset_midframe();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
